// File: rtl/sample_pkg.sv
// Shared types and constants for the pixel-sampling run scheduler.
// Holds the FSM state encoding, default run lengths and default sample points.
package sample_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  localparam int FRAMES_10S = 601;
  localparam int FRAMES_60S = 3601;

  localparam int DEF_NPTS  = 5;
  localparam int DEF_IDX_W = 22;

  // Point 0 sits in the least significant slice.
  localparam logic [DEF_NPTS*DEF_IDX_W-1:0] DEF_PT_IDX = {
    22'd821096, 22'd820456, 22'd562728, 22'd305000, 22'd304360
  };

  function automatic int pt_width(input int npts);
    return (npts > 1) ? $clog2(npts) : 1;
  endfunction

endpackage

// File: rtl/idx_match.sv
// Compares one pixel index against NPTS packed sample indices and reports
// whether any matched, plus the lowest-numbered matching point.
module idx_match
  import sample_pkg::*;
#(
  parameter int NPTS  = 5,
  parameter int IDX_W = 22,
  localparam int PT_W = pt_width(NPTS)
) (
  input  logic [IDX_W-1:0]      idx,
  input  logic [NPTS*IDX_W-1:0] pt_idx,
  output logic                  hit,
  output logic [PT_W-1:0]       pt
);

  // Scanning from the top down lets the lowest matching point win.
  always_comb begin
    hit = 1'b0;
    pt  = '0;
    for (int k = NPTS - 1; k >= 0; k--) begin
      if (pt_idx[k*IDX_W +: IDX_W] == idx) begin
        hit = 1'b1;
        pt  = PT_W'(k);
      end
    end
  end

endmodule

// File: rtl/sample_scheduler.sv
// Sequences one measurement run: arms on a vsync falling edge, runs FRAMES
// frames, strobes at configured pixel indices and flags frame and run ends.
module sample_scheduler
  import sample_pkg::*;
#(
  parameter int FRAMES = FRAMES_10S,
  parameter int NPTS   = DEF_NPTS,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int FRM_W  = 12,
  localparam int PT_W  = pt_width(NPTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  vs,
  input  logic                  pix_valid,
  input  logic [NPTS*IDX_W-1:0] pt_idx,
  output logic                  busy,
  output logic                  running,
  output logic                  sample_stb,
  output logic [PT_W-1:0]       sample_pt,
  output logic                  frame_end,
  output logic [FRM_W-1:0]      frame_cnt,
  output logic                  run_done
);

  sched_state_t     state;
  logic             vs_d;
  logic             vs_fall;
  logic [IDX_W-1:0] pix_cnt;
  logic [IDX_W-1:0] cmp_idx;
  logic             restart;
  logic             stb_next;
  logic             hit;
  logic [PT_W-1:0]  hit_pt;

  assign vs_fall = vs_d & ~vs;

  // A vsync fall in ARM or RUN makes the current pixel index 0 regardless of pix_cnt.
  always_comb begin
    restart  = vs_fall && (state == ARM || state == RUN);
    cmp_idx  = restart ? '0 : pix_cnt;
    stb_next = pix_valid && !abort && hit && (restart || state == RUN);
  end

  idx_match #(
    .NPTS  (NPTS),
    .IDX_W (IDX_W)
  ) u_idx_match (
    .idx    (cmp_idx),
    .pt_idx (pt_idx),
    .hit    (hit),
    .pt     (hit_pt)
  );

  // run_done is registered while in DONE, so it appears the cycle after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vs_d       <= 1'b1;
      pix_cnt    <= '0;
      frame_cnt  <= '0;
      busy       <= 1'b0;
      running    <= 1'b0;
      sample_stb <= 1'b0;
      sample_pt  <= '0;
      frame_end  <= 1'b0;
      run_done   <= 1'b0;
    end else begin
      vs_d       <= vs;
      sample_stb <= stb_next;
      sample_pt  <= stb_next ? hit_pt : '0;
      frame_end  <= 1'b0;
      run_done   <= 1'b0;

      if (abort && state != IDLE) begin
        state   <= IDLE;
        busy    <= 1'b0;
        running <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= ARM;
              frame_cnt <= '0;
              busy      <= 1'b1;
              running   <= 1'b0;
            end
          end

          ARM: begin
            if (vs_fall) begin
              state   <= RUN;
              running <= 1'b1;
              pix_cnt <= pix_valid ? IDX_W'(1) : '0;
            end
          end

          RUN: begin
            if (vs_fall) begin
              pix_cnt   <= pix_valid ? IDX_W'(1) : '0;
              frame_cnt <= frame_cnt + FRM_W'(1);
              frame_end <= 1'b1;
              if (frame_cnt == FRM_W'(FRAMES - 1)) begin
                state   <= DONE;
                busy    <= 1'b0;
                running <= 1'b0;
              end
            end else if (pix_valid && pix_cnt != '1) begin
              pix_cnt <= pix_cnt + IDX_W'(1);
            end
          end

          DONE: begin
            state    <= IDLE;
            run_done <= 1'b1;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_scheduler.sv
// Scoreboard bench for sample_scheduler: expected strobes, frame ends and
// run completions are queued as stimulus is driven and matched to DUT events.
module tb_sample_scheduler;

  localparam int FRAMES = 3;
  localparam int NPTS   = 2;
  localparam int IDX_W  = 8;
  localparam int FRM_W  = 4;
  localparam int MAXIDX = (1 << IDX_W) - 1;

  typedef struct packed {
    int edge_no;
    int val;
  } ev_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  abort;
  logic                  vs;
  logic                  pix_valid;
  logic [NPTS*IDX_W-1:0] pt_idx;
  logic                  busy;
  logic                  running;
  logic                  sample_stb;
  logic [0:0]            sample_pt;
  logic                  frame_end;
  logic [FRM_W-1:0]      frame_cnt;
  logic                  run_done;

  ev_t exp_stb_q[$];
  ev_t obs_stb_q[$];
  ev_t exp_fe_q[$];
  ev_t obs_fe_q[$];
  int  exp_rd_q[$];
  int  obs_rd_q[$];

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  int p0;
  int p1;

  sample_scheduler #(
    .FRAMES (FRAMES),
    .NPTS   (NPTS),
    .IDX_W  (IDX_W),
    .FRM_W  (FRM_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .vs         (vs),
    .pix_valid  (pix_valid),
    .pt_idx     (pt_idx),
    .busy       (busy),
    .running    (running),
    .sample_stb (sample_stb),
    .sample_pt  (sample_pt),
    .frame_end  (frame_end),
    .frame_cnt  (frame_cnt),
    .run_done   (run_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record DUT events mid-cycle, tagged with the edge that produced them.
  always @(negedge clk) begin
    if (!rst) begin
      if (sample_stb) obs_stb_q.push_back(ev_t'{cyc, int'(sample_pt)});
      if (frame_end)  obs_fe_q.push_back(ev_t'{cyc, int'(frame_cnt)});
      if (run_done)   obs_rd_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic pv, input logic st,
                               input logic ab, output int edge_no);
    vs        = v;
    pix_valid = pv;
    start     = st;
    abort     = ab;
    @(posedge clk);
    #1;
    edge_no = cyc;
  endtask

  task automatic pixel_step(inout int idx, output int edge_no);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, edge_no);
    if (idx == p0)      exp_stb_q.push_back(ev_t'{edge_no, 0});
    else if (idx == p1) exp_stb_q.push_back(ev_t'{edge_no, 1});
    idx = (idx == MAXIDX) ? MAXIDX : idx + 1;
  endtask

  task automatic set_points(input int a, input int b);
    p0     = a;
    p1     = b;
    pt_idx = {IDX_W'(b), IDX_W'(a)};
  endtask

  task automatic clear_queues();
    exp_stb_q.delete();
    obs_stb_q.delete();
    exp_fe_q.delete();
    obs_fe_q.delete();
    exp_rd_q.delete();
    obs_rd_q.delete();
  endtask

  task automatic begin_run();
    int e;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, e);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic end_run();
    int e;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, e);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic test_reset();
    int e;
    rst = 1'b1;
    vs = 1'b1; pix_valid = 1'b0; start = 1'b0; abort = 1'b0;
    set_points(10, 4);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, running, sample_stb, sample_pt, frame_end, run_done, frame_cnt} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got busy=%b running=%b stb=%b pt=%0d fe=%b rd=%b fcnt=%0d, expected all 0",
               busy, running, sample_stb, sample_pt, frame_end, run_done, frame_cnt);
    end
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, e);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, e);
    checks++;
    if (busy !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle: got busy=%b running=%b, expected 0 0", busy, running);
    end
  endtask

  task automatic test_sample_points();
    int e;
    int idx;
    clear_queues();
    set_points(10, 4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, e);
    checks++;
    if (busy !== 1'b1 || running !== 1'b0) begin
      failures++;
      $display("[TB] FAIL arm_state: got busy=%b running=%b, expected 1 0", busy, running);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, e);
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("[TB] FAIL run_entry: got running=%b, expected 1", running);
    end
    idx = 0;
    repeat (12) pixel_step(idx, e);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, e);
    checks++;
    if (obs_stb_q.size() != exp_stb_q.size()) begin
      failures++;
      $display("[TB] FAIL points_strobe_count: got %0d expected %0d", obs_stb_q.size(), exp_stb_q.size());
    end
    while (exp_stb_q.size() > 0 && obs_stb_q.size() > 0) begin
      ev_t x = exp_stb_q.pop_front();
      ev_t o = obs_stb_q.pop_front();
      checks++;
      if (o !== x) begin
        failures++;
        $display("[TB] FAIL points_strobe: got edge %0d pt %0d expected edge %0d pt %0d",
                 o.edge_no, o.val, x.edge_no, x.val);
      end
    end
    end_run();
  endtask

  task automatic test_frames();
    int e;
    int idx;
    clear_queues();
    set_points(10, 4);
    begin_run();
    for (int f = 1; f <= FRAMES; f++) begin
      idx = 0;
      repeat (3) pixel_step(idx, e);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, e);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, e);
      exp_fe_q.push_back(ev_t'{e, f});
      if (f == FRAMES) exp_rd_q.push_back(e + 1);
    end
    checks++;
    if (busy !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("[TB] FAIL done_busy: got busy=%b running=%b, expected 0 0", busy, running);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, e);
    checks++;
    if (run_done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL run_done_pulse: got run_done=%b busy=%b, expected 1 0", run_done, busy);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, e);
    checks++;
    if (busy !== 1'b0 || run_done !== 1'b0 || frame_cnt !== FRM_W'(FRAMES)) begin
      failures++;
      $display("[TB] FAIL after_done: got busy=%b run_done=%b frame_cnt=%0d, expected 0 0 %0d",
               busy, run_done, frame_cnt, FRAMES);
    end
    checks++;
    if (obs_fe_q.size() != exp_fe_q.size()) begin
      failures++;
      $display("[TB] FAIL frames_fe_count: got %0d expected %0d", obs_fe_q.size(), exp_fe_q.size());
    end
    while (exp_fe_q.size() > 0 && obs_fe_q.size() > 0) begin
      ev_t x = exp_fe_q.pop_front();
      ev_t o = obs_fe_q.pop_front();
      checks++;
      if (o !== x) begin
        failures++;
        $display("[TB] FAIL frames_fe: got edge %0d cnt %0d expected edge %0d cnt %0d",
                 o.edge_no, o.val, x.edge_no, x.val);
      end
    end
    checks++;
    if (obs_rd_q.size() != exp_rd_q.size()) begin
      failures++;
      $display("[TB] FAIL frames_rd_count: got %0d expected %0d", obs_rd_q.size(), exp_rd_q.size());
    end
    while (exp_rd_q.size() > 0 && obs_rd_q.size() > 0) begin
      int x = exp_rd_q.pop_front();
      int o = obs_rd_q.pop_front();
      checks++;
      if (o !== x) begin
        failures++;
        $display("[TB] FAIL frames_rd_edge: got %0d expected %0d", o, x);
      end
    end
    checks++;
    if (obs_stb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL frames_stray_strobe: got %0d expected 0", obs_stb_q.size());
    end
  endtask

  task automatic test_duplicate();
    int e;
    int idx;
    clear_queues();
    set_points(7, 7);
    begin_run();
    idx = 0;
    repeat (10) pixel_step(idx, e);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, e);
    checks++;
    if (obs_stb_q.size() != exp_stb_q.size()) begin
      failures++;
      $display("[TB] FAIL dup_strobe_count: got %0d expected %0d", obs_stb_q.size(), exp_stb_q.size());
    end
    while (exp_stb_q.size() > 0 && obs_stb_q.size() > 0) begin
      ev_t x = exp_stb_q.pop_front();
      ev_t o = obs_stb_q.pop_front();
      checks++;
      if (o !== x) begin
        failures++;
        $display("[TB] FAIL dup_strobe: got edge %0d pt %0d expected edge %0d pt %0d",
                 o.edge_no, o.val, x.edge_no, x.val);
      end
    end
    end_run();
  endtask

  task automatic test_edge_pixel();
    int e;
    int idx;
    clear_queues();
    set_points(0, 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, e);
    idx = 0;
    pixel_step(idx, e);
    repeat (6) pixel_step(idx, e);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, e);
    idx = 0;
    pixel_step(idx, e);
    exp_fe_q.push_back(ev_t'{e, 1});
    checks++;
    if (sample_stb !== 1'b1 || frame_end !== 1'b1 || sample_pt !== 1'b0) begin
      failures++;
      $display("[TB] FAIL edge_coincide: got stb=%b fe=%b pt=%0d, expected 1 1 0",
               sample_stb, frame_end, sample_pt);
    end
    repeat (5) pixel_step(idx, e);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, e);
    checks++;
    if (obs_stb_q.size() != exp_stb_q.size()) begin
      failures++;
      $display("[TB] FAIL edge_strobe_count: got %0d expected %0d", obs_stb_q.size(), exp_stb_q.size());
    end
    while (exp_stb_q.size() > 0 && obs_stb_q.size() > 0) begin
      ev_t x = exp_stb_q.pop_front();
      ev_t o = obs_stb_q.pop_front();
      checks++;
      if (o !== x) begin
        failures++;
        $display("[TB] FAIL edge_strobe: got edge %0d pt %0d expected edge %0d pt %0d",
                 o.edge_no, o.val, x.edge_no, x.val);
      end
    end
    checks++;
    if (obs_fe_q.size() != exp_fe_q.size()) begin
      failures++;
      $display("[TB] FAIL edge_fe_count: got %0d expected %0d", obs_fe_q.size(), exp_fe_q.size());
    end
    while (exp_fe_q.size() > 0 && obs_fe_q.size() > 0) begin
      ev_t x = exp_fe_q.pop_front();
      ev_t o = obs_fe_q.pop_front();
      checks++;
      if (o !== x) begin
        failures++;
        $display("[TB] FAIL edge_fe: got edge %0d cnt %0d expected edge %0d cnt %0d",
                 o.edge_no, o.val, x.edge_no, x.val);
      end
    end
    end_run();
  endtask

  task automatic test_abort();
    int e;
    int idx;
    clear_queues();
    set_points(10, 4);
    begin_run();
    idx = 0;
    repeat (3) pixel_step(idx, e);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, e);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, e);
    exp_fe_q.push_back(ev_t'{e, 1});
    idx = 0;
    repeat (5) pixel_step(idx, e);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, e);
    checks++;
    if (busy !== 1'b0 || running !== 1'b0 || frame_cnt !== FRM_W'(1)) begin
      failures++;
      $display("[TB] FAIL abort_idle: got busy=%b running=%b frame_cnt=%0d, expected 0 0 1",
               busy, running, frame_cnt);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, e);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, e);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, e);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, e);
    checks++;
    if (obs_fe_q.size() != exp_fe_q.size() || obs_rd_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL abort_events: got fe=%0d rd=%0d expected fe=%0d rd=0",
               obs_fe_q.size(), obs_rd_q.size(), exp_fe_q.size());
    end
    checks++;
    if (obs_stb_q.size() != exp_stb_q.size()) begin
      failures++;
      $display("[TB] FAIL abort_strobe_count: got %0d expected %0d", obs_stb_q.size(), exp_stb_q.size());
    end
    while (exp_stb_q.size() > 0 && obs_stb_q.size() > 0) begin
      ev_t x = exp_stb_q.pop_front();
      ev_t o = obs_stb_q.pop_front();
      checks++;
      if (o !== x) begin
        failures++;
        $display("[TB] FAIL abort_strobe: got edge %0d pt %0d expected edge %0d pt %0d",
                 o.edge_no, o.val, x.edge_no, x.val);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, e);
    checks++;
    if (busy !== 1'b1 || frame_cnt !== '0) begin
      failures++;
      $display("[TB] FAIL rearm_clear: got busy=%b frame_cnt=%0d, expected 1 0", busy, frame_cnt);
    end
    end_run();
  endtask

  task automatic test_reset_mid_run();
    int e;
    int idx;
    clear_queues();
    set_points(10, 4);
    begin_run();
    idx = 0;
    repeat (2) pixel_step(idx, e);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, e);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, e);
    idx = 0;
    repeat (5) pixel_step(idx, e);
    checks++;
    if (sample_stb !== 1'b1 || frame_cnt !== FRM_W'(1)) begin
      failures++;
      $display("[TB] FAIL pre_reset: got stb=%b frame_cnt=%0d, expected 1 1", sample_stb, frame_cnt);
    end
    pix_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, running, sample_stb, sample_pt, frame_end, run_done, frame_cnt} !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset: got busy=%b running=%b stb=%b pt=%0d fe=%b rd=%b fcnt=%0d, expected all 0",
               busy, running, sample_stb, sample_pt, frame_end, run_done, frame_cnt);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, e);
    clear_queues();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, e);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, e);
    checks++;
    if (busy !== 1'b1 || running !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_low_arm: got busy=%b running=%b, expected 1 0", busy, running);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, e);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, e);
    checks++;
    if (running !== 1'b1 || obs_fe_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL rearm_after_reset: got running=%b fe=%0d, expected 1 0", running, obs_fe_q.size());
    end
    end_run();
  endtask

  task automatic test_saturate();
    int e;
    int idx;
    clear_queues();
    set_points(MAXIDX, 3);
    begin_run();
    idx = 0;
    repeat (300) pixel_step(idx, e);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, e);
    checks++;
    if (obs_stb_q.size() != exp_stb_q.size()) begin
      failures++;
      $display("[TB] FAIL sat_strobe_count: got %0d expected %0d", obs_stb_q.size(), exp_stb_q.size());
    end
    while (exp_stb_q.size() > 0 && obs_stb_q.size() > 0) begin
      ev_t x = exp_stb_q.pop_front();
      ev_t o = obs_stb_q.pop_front();
      checks++;
      if (o !== x) begin
        failures++;
        $display("[TB] FAIL sat_strobe: got edge %0d pt %0d expected edge %0d pt %0d",
                 o.edge_no, o.val, x.edge_no, x.val);
      end
    end
    end_run();
  endtask

  initial begin
    test_reset();
    test_sample_points();
    test_frames();
    test_duplicate();
    test_edge_pixel();
    test_abort();
    test_reset_mid_run();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
